hdmi_i2s_multi_tx: RTL and testbench
====================================

// Module: hdmi_i2s_multi_tx
// PURPOSE
//  Parametrised I2S transmitter feeding the ADV7513 audio port of the HDMI TX top.
//  Generates SCLK/LRCLK and NUM_LINES serial data lines (I2S0..3 = up to 8 channels).
//  Samples arrive by valid/ready stream into a frame FIFO, or from an internal test-tone ramp.
//  Standard Philips I2S timing, 64 SCLK per frame; runs on the audio control clock.
// PARAMETERS
//  NUM_LINES   4   serial data lines driven, 1..4
//  SAMPLE_W    16  bits per sample, 16..24, two's complement, MSB first
//  SCLK_DIV    2   clk cycles per SCLK half-period, >=1 (12.288 MHz/2 -> 3.072 MHz SCLK, fs=48 kHz)
//  FIFO_DEPTH  4   frame FIFO entries, power of 2, >=2
//  TONE_STEP   256 ramp increment per frame in tone mode
// PORTS
//  clk         in   1                         audio control clock
//  reset_n     in   1                         asynchronous active-low reset
//  enable      in   1                         1 = run, 0 = stop at the end of the current frame
//  mode        in   1                         0 = stream from FIFO, 1 = internal test tone
//  s_valid     in   1                         input frame valid
//  s_ready     out  1                         FIFO can accept a frame (= !full)
//  s_data      in   NUM_LINES*2*SAMPLE_W      frame; line n: L=[(2n+1)*SAMPLE_W-1 -: SAMPLE_W], R=next SAMPLE_W above
//  sclk        out  1                         I2S bit clock
//  lrclk       out  1                         word select: 0 = left, 1 = right
//  i2s         out  NUM_LINES                 serial data, line n = channels 2n/2n+1
//  fifo_level  out  $clog2(FIFO_DEPTH)+1      frames currently stored
//  underrun    out  1                         one-clk pulse when a frame loads from an empty FIFO in stream mode
// BEHAVIOUR
//  Reset (async, any time): sclk=0, lrclk=0, i2s=0, underrun=0, FIFO flushed (fifo_level=0, s_ready=1), FSM=IDLE.
//  FSM IDLE -> RUN: enable=1 sampled in IDLE. Divider and bitcnt (0..63) clear; first frame loads immediately.
//  RUN -> STOP: enable=0 sampled in RUN. STOP -> IDLE: after the bitcnt=63 slot completes (falling SCLK).
//  STOP -> RUN is not allowed; enable is re-sampled only in IDLE. IDLE/STOP outputs after the frame: sclk=0, lrclk=0, i2s=0.
//  SCLK toggles every SCLK_DIV clk cycles; first rising edge SCLK_DIV cycles after entering RUN.
//  lrclk and i2s change only on SCLK falling edges (one clk after the divider tick). The ADV7513 samples on the rising edge.
//  lrclk = bitcnt[5]; bitcnt advances on each falling edge and wraps 63 -> 0.
//  Slot bit k = bitcnt[4:0]: k=0 drives 0 (I2S one-bit delay); k=1..SAMPLE_W drives sample[SAMPLE_W-k];
//  k>SAMPLE_W drives 0.
//  Frame load: at wrap 63 -> 0, and on IDLE -> RUN, the frame shift registers load in the same cycle:
//   stream: pop FIFO head; if the FIFO is empty, load all zeros and pulse underrun for 1 clk.
//   tone:   L = ramp[SAMPLE_W-1:0] on all lines, R = ~ramp; ramp += TONE_STEP (wraps mod 2^SAMPLE_W);
//   ramp=0 at reset; the FIFO is neither popped nor flushed.
//  The mode input is sampled only at a frame load; a mid-frame change takes effect on the next frame.
//  FIFO: push when s_valid&&s_ready. Full: s_ready=0, no push; a pop in the same cycle does not admit a push.
//   Empty with push and pop in the same cycle: pop sees empty (zeros plus underrun), and the pushed frame is stored.
//   Push while not full and pop while not empty in the same cycle: fifo_level unchanged.
//  FIFO accepts pushes in every FSM state, including IDLE.
//  Latency: a frame pushed into an empty FIFO during RUN appears on i2s starting at the next frame's k=1 bit.
// TESTING
//  T1 reset: assert reset_n=0 mid-frame with FIFO level 3 -> same cycle: sclk=lrclk=i2s=0, fifo_level=0, s_ready=1.
//  T2 stream, NUM_LINES=4, SAMPLE_W=16, SCLK_DIV=2: push frames L0=16'hA5C3, R0=16'h0001, ... then enable -> SCLK period 4 clk;
//   decoded L0 = A5C3, R0 = 0001 on line 0; bit k=0 and k=17..31 = 0; lrclk period = 256 clk.
//  T3 underrun: enable with the FIFO empty -> underrun pulses once per frame and i2s stays 0; push one frame -> it is
//   sent on the next frame, then underrun resumes.
//  T4 FIFO boundary: with enable=0, push 4 frames (FIFO_DEPTH=4) -> s_ready=0 and fifo_level=4; a 5th s_valid is not accepted;
//   enable -> after the first load, s_ready=1 and fifo_level=3.
//  T5 tone: mode=1, TONE_STEP=256 -> successive left samples 0000, 0100, 0200; right samples FFFF, FEFF; identical on
//   all 4 lines; fifo_level unchanged.
//  T6 stop: drop enable at bitcnt=10 -> frame completes through bitcnt=63, then sclk=lrclk=i2s=0 in IDLE;
//   re-enable -> restarts at bitcnt=0, lrclk=0.

Source files
------------

// File: rtl/hdmi_i2s_multi_tx.sv
// Philips I2S transmitter for the ADV7513 audio port: 64 SCLK per frame, NUM_LINES data lines,
// frames from a valid/ready FIFO or from an internal test-tone ramp.
module hdmi_i2s_multi_tx #(
   parameter int NUM_LINES  = 4,
   parameter int SAMPLE_W   = 16,
   parameter int SCLK_DIV   = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TONE_STEP  = 256
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            enable,
   input  logic                            mode,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [NUM_LINES*2*SAMPLE_W-1:0] s_data,
   output logic                            sclk,
   output logic                            lrclk,
   output logic [NUM_LINES-1:0]            i2s,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            underrun
);

   localparam int FRAME_W = NUM_LINES * 2 * SAMPLE_W;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

   localparam logic [AW:0]          FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
   localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(SCLK_DIV - 1);
   localparam logic [SAMPLE_W-1:0]  RAMP_INC   = SAMPLE_W'(TONE_STEP);
   localparam logic [5:0]           LAST_SLOT  = 6'(SAMPLE_W);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

   state_t               state;
   logic [FRAME_W-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [FRAME_W-1:0]   frame;
   logic [FRAME_W-1:0]   tone_frame;
   logic [FRAME_W-1:0]   next_frame;
   logic [SAMPLE_W-1:0]  ramp;
   logic [DIV_W-1:0]     div;
   logic [5:0]           bitcnt;
   logic [5:0]           next_cnt;
   logic [4:0]           slot;
   logic                 slot_on;
   logic [NUM_LINES-1:0] i2s_next;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 push;
   logic                 pop;
   logic                 tick;
   logic                 fall;
   logic                 wrap;
   logic                 start;
   logic                 load;

   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == FULL_LEVEL);
   assign s_ready    = !fifo_full;
   assign push       = s_valid && !fifo_full;

   assign tick  = (state != IDLE) && (div == DIV_LAST);
   assign fall  = tick && sclk;
   assign wrap  = fall && (bitcnt == 6'd63);
   assign start = (state == IDLE) && enable;
   assign load  = start || (wrap && (state == RUN));
   assign pop   = load && !mode && !fifo_empty;

   assign next_cnt   = bitcnt + 6'd1;
   assign slot       = next_cnt[4:0];
   // Slot 0 is the one-bit I2S delay; slots past the sample width are zero padding.
   assign slot_on    = (slot != 5'd0) && ({1'b0, slot} <= LAST_SLOT);
   assign next_frame = mode ? tone_frame : (fifo_empty ? '0 : mem[rd_ptr]);

   for (genvar n = 0; n < NUM_LINES; n++) begin : g_line
      logic [SAMPLE_W-1:0] shifted;
      assign tone_frame[2*n*SAMPLE_W +: SAMPLE_W]     = ramp;
      assign tone_frame[(2*n+1)*SAMPLE_W +: SAMPLE_W] = ~ramp;
      assign shifted = (next_cnt[5] ? frame[(2*n+1)*SAMPLE_W +: SAMPLE_W]
                                    : frame[2*n*SAMPLE_W +: SAMPLE_W]) << (slot - 5'd1);
      assign i2s_next[n] = slot_on & shifted[SAMPLE_W-1];
   end

   // NOTE: sample storage has no reset; flushing the FIFO only clears pointers and level.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      fifo_level <= fifo_level + (AW + 1)'(1);
         else if (pop && !push) fifo_level <= fifo_level - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         div      <= '0;
         sclk     <= 1'b0;
         bitcnt   <= '0;
         lrclk    <= 1'b0;
         i2s      <= '0;
         frame    <= '0;
         ramp     <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= load && !mode && fifo_empty;
         if (load) begin
            frame <= next_frame;
            if (mode) ramp <= ramp + RAMP_INC;
         end
         case (state)
            IDLE: begin
               div    <= '0;
               sclk   <= 1'b0;
               bitcnt <= '0;
               lrclk  <= 1'b0;
               i2s    <= '0;
               if (enable) state <= RUN;
            end
            RUN, STOP: begin
               div <= tick ? '0 : div + DIV_W'(1);
               if (tick) sclk <= ~sclk;
               // Data and word select move on the falling SCLK edge, so they are stable at the rise.
               if (fall) begin
                  bitcnt <= next_cnt;
                  lrclk  <= next_cnt[5];
                  i2s    <= i2s_next;
               end
               if (state == RUN && !enable) state <= STOP;
               if (state == STOP && wrap)   state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hdmi_i2s_multi_tx.sv
// Bench for hdmi_i2s_multi_tx: a reference model queues expected frames at each frame load,
// and a serial decoder rebuilds frames from sclk/lrclk/i2s and compares them against the queue.
module tb_hdmi_i2s_multi_tx;

   localparam int NL    = 4;
   localparam int SW    = 16;
   localparam int DIV   = 2;
   localparam int DEPTH = 4;
   localparam int STEP  = 256;
   localparam int FW    = NL * 2 * SW;

   typedef enum int {M_IDLE, M_RUN, M_STOP} mstate_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          mode = 1'b0;
   logic          s_valid = 1'b0;
   logic [FW-1:0] s_data = '0;
   logic          s_ready;
   logic          sclk;
   logic          lrclk;
   logic [NL-1:0] i2s;
   logic [2:0]    fifo_level;
   logic          underrun;

   always #5 clk = ~clk;

   hdmi_i2s_multi_tx #(
      .NUM_LINES(NL), .SAMPLE_W(SW), .SCLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .TONE_STEP(STEP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .sclk(sclk), .lrclk(lrclk), .i2s(i2s), .fifo_level(fifo_level), .underrun(underrun)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // reference model and decoder state
   mstate_t       m_state;
   int            m_cyc;
   logic [SW-1:0] m_ramp;
   logic [FW-1:0] m_fifo[$];
   logic [FW-1:0] exp_q[$];
   int            m_ur = 0;
   int            dut_ur = 0;
   int            lvl_err = 0;
   int            idle_err = 0;
   int            cyc = 0;
   logic          sclk_q;
   int            pos;
   int            last_rise;
   int            first_rise;
   logic [FW-1:0] cap;
   logic          pad_err, lr_err, per_err;

   task automatic model_reset();
      m_state = M_IDLE;
      m_cyc   = 0;
      m_ramp  = '0;
      m_fifo.delete();
      exp_q.delete();
      sclk_q    = 1'b0;
      pos       = 0;
      last_rise = -1;
      cap       = '0;
      pad_err   = 1'b0;
      lr_err    = 1'b0;
      per_err   = 1'b0;
   endtask

   function automatic logic [FW-1:0] mk_frame(input logic [SW-1:0] l0, input logic [SW-1:0] r0);
      logic [FW-1:0] f;
      f = '0;
      for (int n = 0; n < NL; n++) begin
         f[2*n*SW +: SW]     = l0 ^ SW'(n * 32'h1111);
         f[(2*n+1)*SW +: SW] = r0 + SW'(3 * n);
      end
      return f;
   endfunction

   // One clock: inputs are sampled at the rising edge, outputs are examined at the falling edge.
   task automatic tick();
      logic          en_s, mode_s, valid_s, load, full;
      logic [FW-1:0] data_s, fr, want;
      mstate_t       st0;
      int            k, lr;
      @(posedge clk);
      en_s = enable; mode_s = mode; valid_s = s_valid; data_s = s_data;
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
         model_reset();
         return;
      end
      st0  = m_state;
      load = 1'b0;
      full = (m_fifo.size() == DEPTH);
      if (st0 == M_IDLE) begin
         if (en_s) begin
            load = 1'b1; m_state = M_RUN; m_cyc = 0;
            first_rise = cyc + DIV; last_rise = -1;
         end
      end else begin
         m_cyc++;
         if (m_cyc == 256) begin
            m_cyc = 0;
            if (st0 == M_STOP) m_state = M_IDLE;
            else load = 1'b1;
         end
         if (st0 == M_RUN && !en_s) m_state = M_STOP;
      end
      if (load) begin
         fr = '0;
         if (mode_s) begin
            for (int n = 0; n < NL; n++) begin
               fr[2*n*SW +: SW]     = m_ramp;
               fr[(2*n+1)*SW +: SW] = ~m_ramp;
            end
            m_ramp = m_ramp + SW'(STEP);
         end else if (m_fifo.size() == 0) begin
            m_ur++;
         end else begin
            fr = m_fifo.pop_front();
         end
         exp_q.push_back(fr);
      end
      if (valid_s && !full) m_fifo.push_back(data_s);

      if (fifo_level !== 3'(m_fifo.size()) || s_ready !== (m_fifo.size() < DEPTH)) lvl_err++;
      if (underrun === 1'b1) dut_ur++;
      if (m_state == M_IDLE) begin
         pos = 0; last_rise = -1;
         if ({sclk, lrclk, i2s} !== '0) idle_err++;
      end

      if (sclk === 1'b1 && sclk_q === 1'b0) begin
         if (last_rise < 0) begin
            if (cyc != first_rise) per_err = 1'b1;
         end else if (cyc - last_rise != 2 * DIV) per_err = 1'b1;
         last_rise = cyc;
         k  = pos % 32;
         lr = pos / 32;
         if (lrclk !== 1'(lr)) lr_err = 1'b1;
         for (int n = 0; n < NL; n++) begin
            if (k >= 1 && k <= SW) cap[(2*n+lr)*SW + SW - k] = i2s[n];
            else if (i2s[n] !== 1'b0) pad_err = 1'b1;
         end
         if (pos == 63) begin
            if (exp_q.size() == 0) check("exp_q_nonempty", FW'(exp_q.size()), FW'(1));
            else begin
               want = exp_q.pop_front();
               check("frame", cap, want);
            end
            check("framing", FW'({per_err, pad_err, lr_err}), FW'(0));
            cap = '0; pad_err = 1'b0; lr_err = 1'b0; per_err = 1'b0;
            pos = 0;
         end else begin
            pos++;
         end
      end
      sclk_q = sclk;
   endtask

   task automatic push_frame(input logic [FW-1:0] f);
      s_valid = 1'b1;
      s_data  = f;
      tick();
      s_valid = 1'b0;
      s_data  = '0;
   endtask

   task automatic run_until_idle();
      for (int i = 0; i < 700 && m_state != M_IDLE; i++) tick();
      repeat (3) tick();
      check("idle_outputs", FW'({sclk, lrclk, i2s}), FW'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) tick();
      check("rst_outputs", FW'({sclk, lrclk, i2s, underrun}), FW'(0));
      check("rst_level", FW'(fifo_level), FW'(0));
      check("rst_ready", FW'(s_ready), FW'(1));
      reset_n = 1'b1;
      repeat (2) tick();

      // FIFO boundary, then stream playback; frame 0 carries L0=A5C3, R0=0001
      push_frame(mk_frame(16'hA5C3, 16'h0001));
      push_frame(mk_frame(16'h8000, 16'h7FFF));
      push_frame(mk_frame(16'hFFFF, 16'h0000));
      push_frame(mk_frame(16'h1234, 16'hABCD));
      check("full_level", FW'(fifo_level), FW'(4));
      check("full_ready", FW'(s_ready), FW'(0));
      push_frame(mk_frame(16'hDEAD, 16'hBEEF));
      check("full_reject", FW'(fifo_level), FW'(4));
      enable = 1'b1;
      tick();
      check("first_load_level", FW'(fifo_level), FW'(3));
      check("first_load_ready", FW'(s_ready), FW'(1));
      repeat (6 * 256 + 100) tick();

      // underrun then a single late frame
      check("underrun_count_a", FW'(dut_ur), FW'(m_ur));
      push_frame(mk_frame(16'h5A5A, 16'hC3C3));
      repeat (3 * 256) tick();
      check("underrun_count_b", FW'(dut_ur), FW'(m_ur));

      // stop mid-frame, then restart
      for (int i = 0; i < 600 && pos != 10; i++) tick();
      check("reach_bit10", FW'(pos), FW'(10));
      enable = 1'b0;
      run_until_idle();
      enable = 1'b1;
      repeat (2 * 256 + 20) tick();
      enable = 1'b0;
      run_until_idle();

      // test tone with a queued frame that must stay put until mode returns to stream
      mode = 1'b1;
      push_frame(mk_frame(16'h0F0F, 16'hF0F0));
      check("tone_level_before", FW'(fifo_level), FW'(1));
      enable = 1'b1;
      repeat (2 * 256 + 100) tick();
      check("tone_level_during", FW'(fifo_level), FW'(1));
      mode = 1'b0;
      repeat (200) tick();
      check("tone_level_after", FW'(fifo_level), FW'(0));
      enable = 1'b0;
      run_until_idle();
      check("exp_q_drained", FW'(exp_q.size()), FW'(0));

      // asynchronous reset mid-frame with three frames queued
      mode = 1'b1;
      push_frame(mk_frame(16'h1111, 16'h2222));
      push_frame(mk_frame(16'h3333, 16'h4444));
      push_frame(mk_frame(16'h5555, 16'h6666));
      enable = 1'b1;
      repeat (100) tick();
      check("pre_reset_level", FW'(fifo_level), FW'(3));
      check("pre_reset_sclk_run", FW'(last_rise > 0), FW'(1));
      check("level_monitor", FW'(lvl_err), FW'(0));
      check("idle_monitor", FW'(idle_err), FW'(0));
      check("underrun_total", FW'(dut_ur), FW'(m_ur));
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_outputs", FW'({sclk, lrclk, i2s, underrun}), FW'(0));
      check("async_rst_level", FW'(fifo_level), FW'(0));
      check("async_rst_ready", FW'(s_ready), FW'(1));
      enable = 1'b0;
      mode   = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (4) tick();
      check("post_rst_outputs", FW'({sclk, lrclk, i2s, underrun}), FW'(0));
      check("post_rst_level", FW'(fifo_level), FW'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
